mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning word-index bits; the array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 3, meaning clock edges from request acceptance to the mem_resp cycle; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port mem_read, input, 1, read request, held by the initiator until mem_resp.
REQ-006 SHALL have port mem_write, input, 1, write request, held by the initiator until mem_resp.
REQ-007 SHALL have port mem_byte_enable, input, 4, per-byte write mask; bit i enables byte lane i.
REQ-008 SHALL have port mem_address, input, 32, byte address; bits [1:0] are ignored.
REQ-009 SHALL have port mem_wdata, input, 32, write data.
REQ-010 SHALL have port mem_rdata, output, 32, registered read data.
REQ-011 SHALL have port mem_resp, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port mem_err, output, 1, error flag, valid only while mem_resp=1.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, and RESP.
REQ-014 IDLE SHALL accept a request on the edge where mem_read|mem_write=1, latching address, wdata, byte_enable, and operation.
REQ-015 After acceptance, the FSM SHALL go to BUSY with counter=LATENCY-1, or directly to RESP if LATENCY=1.
REQ-016 BUSY SHALL decrement the counter each edge and enter RESP when the counter reaches 1.
REQ-017 mem_resp SHALL be 1 for exactly the one cycle spent in RESP; the FSM then returns to IDLE unconditionally.
REQ-018 Input changes during BUSY/RESP SHALL be ignored; only the latched request is used.
REQ-019 For a read, mem_rdata SHALL present the array word during the RESP cycle and hold it until the next read response.
REQ-020 For a write, the array SHALL commit only the enabled byte lanes on the edge ending the RESP cycle; byte_enable=0000 SHALL be a legal no-op completing normally.
REQ-021 A request with mem_read and mem_write both 1 SHALL complete with mem_err=1, no array update, and mem_rdata unchanged.
REQ-022 A request still asserted in the IDLE cycle after RESP SHALL be accepted as a new request, giving back-to-back spacing of LATENCY+1 cycles.
REQ-023 mem_err SHALL be 0 outside RESP.

Reset
REQ-024 Asserting rst (low) SHALL force state=IDLE, counter=0, mem_resp=0, mem_err=0, and mem_rdata=0 immediately, without waiting for clk.
REQ-025 Reset during BUSY/RESP SHALL abort the transaction; a pending write SHALL NOT commit.
REQ-026 Array contents SHALL NOT be affected by reset.
REQ-027 The first acceptance after reset release SHALL occur no earlier than the first rising edge with rst=1.

Configuration
REQ-028 Macro MEM_RESPONDER_RANGE_CHECK_EN SHALL enable range checking.
REQ-029 With the macro defined, a request with any of mem_address[31:ADDR_WIDTH+2] nonzero SHALL complete with mem_err=1, mem_rdata=0, and no array write.
REQ-030 Without the macro, upper address bits SHALL be ignored (address wraps modulo array size) and mem_err SHALL only flag the REQ-021 case.

Structure
REQ-031 Package mem_responder_types SHALL hold the state enum (IDLE, BUSY, RESP), the LATENCY default, and the counter width constant (4).
REQ-032 Sub-module mem_array SHALL hold the storage: synchronous byte-enabled write and combinational read, indexed by the word address.

Verification
REQ-033 Read after reset, LATENCY=3: preload word 0x10 = 0xDEADBEEF, read 0x40 -> mem_resp exactly 3 edges after acceptance, mem_rdata=0xDEADBEEF, mem_err=0.
REQ-034 Byte write: word 0x10 = 0xDEADBEEF, write 0x40 with wdata 0x11223344 and byte_enable 0101, then read -> 0xDE22BE44.
REQ-035 Simultaneous read+write at 0x40 -> mem_resp with mem_err=1, word unchanged, mem_rdata unchanged.
REQ-036 Reset mid-write: drop rst in BUSY -> mem_resp=0 immediately, later read returns the old word.
REQ-037 Back-to-back reads held high -> mem_resp pulses every 4 cycles at LATENCY=3; with LATENCY=1, every 2 cycles.
REQ-038 With MEM_RESPONDER_RANGE_CHECK_EN, read 0x0000_0400 at ADDR_WIDTH=8 -> mem_err=1, mem_rdata=0; without it, returns word 0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory model.
// The package name is mem_responder_types.
package mem_responder_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LATENCY_DEFAULT = 3;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_responder_array.sv
// Word-organised storage for mem_responder.
// It has a synchronous byte-enabled write port and a combinational read port.
module mem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: it accepts one request, waits LATENCY edges, then pulses mem_resp.
// Define MEM_RESPONDER_RANGE_CHECK_EN to flag addresses beyond the array with mem_err.
module mem_responder
    import mem_responder_types::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    localparam bit SINGLE = (LATENCY == 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;

    logic                  op_rd;
    logic                  op_wr;
    logic                  range_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;

    logic                  req_in;
    logic                  range_in;
    logic                  accept;
    logic                  enter_resp;
    logic                  cur_rd;
    logic                  cur_wr;
    logic                  cur_range;
    logic                  cur_err;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [31:0]           rdata_arr;
    logic                  we;
    logic                  unused_addr_bits;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    assign range_in = |mem_address[31:ADDR_WIDTH+2];
`else
    assign range_in = 1'b0;
`endif

    assign unused_addr_bits = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

    assign req_in = mem_read | mem_write;
    assign accept = (state == IDLE) & req_in;

    // With LATENCY=1 the response is set up on the acceptance edge itself, so live inputs stand in for the latches.
    assign cur_rd    = (state == IDLE) ? mem_read : op_rd;
    assign cur_wr    = (state == IDLE) ? mem_write : op_wr;
    assign cur_range = (state == IDLE) ? range_in : range_q;
    assign raddr     = (state == IDLE) ? mem_address[ADDR_WIDTH+1:2] : addr_q;
    assign cur_err   = (cur_rd & cur_wr) | cur_range;

    assign enter_resp = (accept & SINGLE) | ((state == BUSY) & (cnt == CNT_W'(1)));

    assign we = (state == RESP) & op_wr & ~op_rd & ~range_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_resp  <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_resp <= enter_resp;
            mem_err  <= enter_resp & cur_err;
            if (enter_resp) begin
                if (cur_range)
                    mem_rdata <= '0;
                else if (cur_rd & ~cur_wr)
                    mem_rdata <= rdata_arr;
            end
            case (state)
                IDLE: begin
                    if (req_in) begin
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= SINGLE ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request latches carry no reset; a write is gated by state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_rd   <= mem_read;
            op_wr   <= mem_write;
            range_q <= range_in;
            addr_q  <= mem_address[ADDR_WIDTH+1:2];
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
        end
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .be   (be_q),
        .waddr(addr_q),
        .wdata(wdata_q),
        .raddr(raddr),
        .rdata(rdata_arr)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: it uses a LATENCY=3 instance for function tests and a LATENCY=1 instance for spacing.
// Range-check expectations follow MEM_RESPONDER_RANGE_CHECK_EN.
module tb_mem_responder;

    localparam int AW  = 8;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp, mem_err;

    logic        r1, w1;
    logic [3:0]  be1;
    logic [31:0] a1, wd1;
    logic [31:0] rdata1;
    logic        resp1, err1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [256];
    logic [31:0] last_rdata;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .mem_err(mem_err)
    );

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .mem_read(r1), .mem_write(w1),
        .mem_byte_enable(be1), .mem_address(a1),
        .mem_wdata(wd1), .mem_rdata(rdata1),
        .mem_resp(resp1), .mem_err(err1)
    );

    task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input string name);
        exp_t       e;
        logic [7:0] idx;
        logic       range_bad;
        int         n;
        bit         got;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        range_bad = |addr[31:AW+2];
`else
        range_bad = 1'b0;
`endif
        idx = addr[AW+1:2];
        if (range_bad) last_rdata = 32'h0;
        else if (rd && !wr) last_rdata = model[idx];
        if (wr && !rd && !range_bad) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
        end
        e.rdata = last_rdata;
        e.err   = (rd & wr) | range_bad;
        sb.push_back(e);

        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_wdata = wd; mem_byte_enable = be;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (mem_resp === 1'b1) got = 1;
            else begin
                checks++;
                if (mem_err !== 1'b0) begin
                    failures++;
                    $display("FAIL %s err_idle: got %b want 0", name, mem_err);
                end
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s timeout: no mem_resp within %0d edges", name, n);
        end else begin
            if (n !== LAT) begin
                failures++;
                $display("FAIL %s latency: got %0d want %0d", name, n, LAT);
            end
            checks++;
            if (mem_err !== e.err) begin
                failures++;
                $display("FAIL %s err: got %b want %b", name, mem_err, e.err);
            end
            checks++;
            if (mem_rdata !== e.rdata) begin
                failures++;
                $display("FAIL %s rdata: got %h want %h", name, mem_rdata, e.rdata);
            end
            @(posedge clk); #1;
            checks++;
            if (mem_resp !== 1'b0 || mem_err !== 1'b0) begin
                failures++;
                $display("FAIL %s pulse_width: resp=%b err=%b want 0 0", name, mem_resp, mem_err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++;
        if (mem_resp !== 1'b0 || mem_err !== 1'b0 || mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: resp=%b err=%b rdata=%h want 0 0 0", mem_resp, mem_err, mem_rdata);
        end
        mem_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_resp !== 1'b0 || mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: resp=%b rdata=%h want 0 0", mem_resp, mem_rdata);
        end
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read();
        req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, "preload_40");
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "read_40");
        checks++;
        if (mem_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_const: got %h want deadbeef", mem_rdata);
        end
    endtask

    task automatic test_byte_write();
        req(1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0101, "byte_write");
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "byte_read");
        checks++;
        if (mem_rdata !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL byte_const: got %h want de22be44", mem_rdata);
        end
        req(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, "be_zero_write");
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "be_zero_read");
    endtask

    task automatic test_rw_conflict();
        req(1'b1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, "rw_conflict");
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "rw_after_read");
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        mem_write = 1'b1; mem_address = 32'h40; mem_wdata = 32'h0; mem_byte_enable = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_resp !== 1'b0) begin
            failures++;
            $display("FAIL midrst_busy: resp=%b want 0", mem_resp);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_resp !== 1'b0 || mem_err !== 1'b0 || mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL midrst_async: resp=%b err=%b rdata=%h want 0 0 0", mem_resp, mem_err, mem_rdata);
        end
        mem_write = 1'b0;
        last_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_resp !== 1'b0) begin
            failures++;
            $display("FAIL midrst_noresp: resp=%b want 0", mem_resp);
        end
        @(negedge clk);
        rst = 1'b1;
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "midrst_read");
        checks++;
        if (mem_rdata !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL midrst_old_word: got %h want de22be44", mem_rdata);
        end
    endtask

    task automatic test_range();
        req(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, "word0_write");
        req(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, "range_read");
        req(1'b0, 1'b1, 32'h400, 32'h01020304, 4'hF, "range_write");
        req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, "word0_read");
    endtask

    task automatic test_back_to_back();
        int  p3[$];
        int  p1[$];
        bit  got;
        @(negedge clk);
        mem_read = 1'b1; mem_address = 32'h40;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (mem_resp === 1'b1) begin
                p3.push_back(c);
                checks++;
                if (mem_rdata !== model[16]) begin
                    failures++;
                    $display("FAIL b2b3_rdata: got %h want %h", mem_rdata, model[16]);
                end
            end
        end
        mem_read = 1'b0;
        repeat (6) @(posedge clk);
        checks++;
        if (p3.size() !== 3) begin
            failures++;
            $display("FAIL b2b3_count: got %0d pulses want 3", p3.size());
        end
        for (int i = 0; i < p3.size(); i++) begin
            checks++;
            if (p3[i] !== 3 + 4*i) begin
                failures++;
                $display("FAIL b2b3_spacing: pulse %0d at edge %0d want %0d", i, p3[i], 3 + 4*i);
            end
        end

        @(negedge clk);
        w1 = 1'b1; a1 = 32'h40; wd1 = 32'hA5A5A5A5; be1 = 4'hF;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            if (resp1 === 1'b1) got = 1;
        end
        w1 = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL lat1_write: timeout got no resp want resp");
        end
        @(negedge clk);
        @(negedge clk);
        r1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (resp1 === 1'b1) begin
                p1.push_back(c);
                checks++;
                if (rdata1 !== 32'hA5A5A5A5 || err1 !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b1_data: rdata=%h err=%b want a5a5a5a5 0", rdata1, err1);
                end
            end
        end
        r1 = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (p1.size() !== 5) begin
            failures++;
            $display("FAIL b2b1_count: got %0d pulses want 5", p1.size());
        end
        for (int i = 0; i < p1.size(); i++) begin
            checks++;
            if (p1[i] !== 1 + 2*i) begin
                failures++;
                $display("FAIL b2b1_spacing: pulse %0d at edge %0d want %0d", i, p1[i], 1 + 2*i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'h0;
        mem_address = 32'h0; mem_wdata = 32'h0;
        r1 = 1'b0; w1 = 1'b0; be1 = 4'h0; a1 = 32'h0; wd1 = 32'h0;
        last_rdata = 32'h0;
        test_reset();
        test_read();
        test_byte_write();
        test_rw_conflict();
        test_reset_mid_write();
        test_range();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
